// File: rtl/mul_arbiter_if.sv
// mul_arbiter_if: request/response and multiplier-side signals of mul_arbiter.
//   i_req, i_req_x, i_req_y  : per-port requests and packed operands (port k at [k*DW +: DW])
//   o_gnt                    : one-hot grant pulse
//   o_rsp_valid, o_rsp_data  : one-hot response valid and shared result bus
//   i_rsp_ready              : per-port result accept
//   o_mul_start, o_mul_x/y   : start pulse and operands towards the multiplier
//   i_mul_done, i_mul_result : multiplier completion pulse and product
//   o_busy, o_timeout        : activity flag and sticky watchdog flag
// The slave modport is the arbiter; the master modport is the requester/multiplier side.
interface mul_arbiter_if #(
  parameter int N_REQ = 4,
  parameter int DW    = 256
);
  logic [N_REQ-1:0]    i_req;
  logic [N_REQ*DW-1:0] i_req_x;
  logic [N_REQ*DW-1:0] i_req_y;
  logic [N_REQ-1:0]    o_gnt;
  logic [N_REQ-1:0]    o_rsp_valid;
  logic [DW-1:0]       o_rsp_data;
  logic [N_REQ-1:0]    i_rsp_ready;
  logic                o_mul_start;
  logic [DW-1:0]       o_mul_x;
  logic [DW-1:0]       o_mul_y;
  logic                i_mul_done;
  logic [DW-1:0]       i_mul_result;
  logic                o_busy;
  logic                o_timeout;

  modport slave (
    input  i_req, i_req_x, i_req_y, i_rsp_ready, i_mul_done, i_mul_result,
    output o_gnt, o_rsp_valid, o_rsp_data, o_mul_start, o_mul_x, o_mul_y,
           o_busy, o_timeout
  );

  modport master (
    output i_req, i_req_x, i_req_y, i_rsp_ready, i_mul_done, i_mul_result,
    input  o_gnt, o_rsp_valid, o_rsp_data, o_mul_start, o_mul_x, o_mul_y,
           o_busy, o_timeout
  );
endinterface

// File: rtl/mul_arbiter.sv
// mul_arbiter: round-robin sharing of one multi-cycle modular multiplier.
//   i_clk : clock, rising edge
//   i_rst : asynchronous active-low reset
//   bus   : mul_arbiter_if.slave (requests, grants, responses, multiplier side)
// A winner is picked in IDLE, its operands are latched and granted, the
// multiplier is started in ISSUE, WAIT collects the product (or the watchdog
// fires), and RESP holds the result until the owner accepts it.
module mul_arbiter #(
  parameter int N_REQ   = 4,
  parameter int DW      = 256,
  parameter int TIMEOUT = 63
) (
  input  logic          i_clk,
  input  logic          i_rst,
  mul_arbiter_if.slave  bus
);

  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t            state_q, state_d;
  logic [PW-1:0]     ptr_q, ptr_d;       // last winner; also the owner of the current transaction
  logic [7:0]        wdog_q, wdog_d;
  logic [N_REQ-1:0]  gnt_q, gnt_d;
  logic [N_REQ-1:0]  rsp_valid_q, rsp_valid_d;
  logic [DW-1:0]     rsp_data_q, rsp_data_d;
  logic              mul_start_q, mul_start_d;
  logic [DW-1:0]     mul_x_q, mul_x_d;
  logic [DW-1:0]     mul_y_q, mul_y_d;
  logic              busy_q, busy_d;
  logic              timeout_q, timeout_d;

  logic              pick_found;
  logic [PW-1:0]     pick_idx;
  logic [N_REQ-1:0]  owner_oh;

  // Scan upward from ptr+1, wrapping, so the last winner has lowest priority.
  function automatic logic [PW:0] rr_pick(input logic [N_REQ-1:0] req,
                                          input logic [PW-1:0]    ptr);
    logic          found;
    logic [PW-1:0] pick;
    int            idx;
    found = 1'b0;
    pick  = '0;
    for (int i = 1; i <= N_REQ; i++) begin
      idx = (int'(ptr) + i) % N_REQ;
      if (!found && req[idx]) begin
        found = 1'b1;
        pick  = PW'(idx);
      end
    end
    return {found, pick};
  endfunction

  assign {pick_found, pick_idx} = rr_pick(bus.i_req, ptr_q);
  assign owner_oh = N_REQ'(1) << ptr_q;

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
    state_d     = state_q;
    ptr_d       = ptr_q;
    wdog_d      = wdog_q;
    gnt_d       = '0;
    mul_start_d = 1'b0;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    mul_x_d     = mul_x_q;
    mul_y_d     = mul_y_q;
    timeout_d   = timeout_q;

    case (state_q)
      IDLE: begin
        if (pick_found) begin
          gnt_d   = N_REQ'(1) << pick_idx;
          mul_x_d = bus.i_req_x[int'(pick_idx)*DW +: DW];
          mul_y_d = bus.i_req_y[int'(pick_idx)*DW +: DW];
          ptr_d   = pick_idx;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        mul_start_d = 1'b1;
        wdog_d      = '0;
        state_d     = WAIT;
      end
      WAIT: begin
        wdog_d = wdog_q + 8'd1;
        // A completion in the same cycle as expiry wins over the watchdog.
        if (bus.i_mul_done) begin
          rsp_data_d  = bus.i_mul_result;
          rsp_valid_d = owner_oh;
          state_d     = RESP;
        end else if ((wdog_q + 8'd1) == 8'(TIMEOUT)) begin
          timeout_d   = 1'b1;
          rsp_data_d  = '0;
          rsp_valid_d = owner_oh;
          state_d     = RESP;
        end
      end
      RESP: begin
        if (bus.i_rsp_ready[ptr_q]) begin
          rsp_valid_d = '0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q     <= IDLE;
      ptr_q       <= PW'(N_REQ - 1);
      wdog_q      <= '0;
      gnt_q       <= '0;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
      mul_start_q <= 1'b0;
      mul_x_q     <= '0;
      mul_y_q     <= '0;
      busy_q      <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      wdog_q      <= wdog_d;
      gnt_q       <= gnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      mul_start_q <= mul_start_d;
      mul_x_q     <= mul_x_d;
      mul_y_q     <= mul_y_d;
      busy_q      <= busy_d;
      timeout_q   <= timeout_d;
    end
  end

  assign bus.o_gnt       = gnt_q;
  assign bus.o_rsp_valid = rsp_valid_q;
  assign bus.o_rsp_data  = rsp_data_q;
  assign bus.o_mul_start = mul_start_q;
  assign bus.o_mul_x     = mul_x_q;
  assign bus.o_mul_y     = mul_y_q;
  assign bus.o_busy      = busy_q;
  assign bus.o_timeout   = timeout_q;

endmodule

// File: tb/tb_mul_arbiter.sv
// tb_mul_arbiter: directed bench for mul_arbiter with a behavioural multiplier
// (fixed latency after start, optional hang, optional stray done pulses).
module tb_mul_arbiter;

  localparam int N   = 4;
  localparam int DW  = 256;
  localparam int LAT = 10;

  logic i_clk;
  logic i_rst;

  mul_arbiter_if #(.N_REQ(N), .DW(DW)) bus ();

  mul_arbiter #(.N_REQ(N), .DW(DW), .TIMEOUT(63)) dut (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;
  always @(posedge i_clk) cyc++;

  // Multiplier model: done asserted LAT cycles after the cycle start is seen.
  logic          hang;
  logic          stray_done;
  logic          m_done;
  logic [DW-1:0] m_result;
  logic [DW-1:0] m_prod;
  int            m_cnt;

  assign bus.i_mul_done   = m_done | stray_done;
  assign bus.i_mul_result = stray_done ? DW'(32'hDEAD) : m_result;

  initial begin
    m_done = 1'b0; m_result = '0; m_prod = '0; m_cnt = 0;
  end

  always @(negedge i_clk) begin
    m_done = 1'b0;
    if (!i_rst) begin
      m_cnt = 0;
    end else begin
      if (m_cnt > 0) begin
        m_cnt--;
        if (m_cnt == 0) begin
          m_done   = 1'b1;
          m_result = m_prod;
        end
      end
      if (bus.o_mul_start && !hang) begin
        m_cnt  = LAT;
        m_prod = bus.o_mul_x * bus.o_mul_y;
      end
    end
  end

  task automatic set_ops(input int port, input logic [DW-1:0] x, input logic [DW-1:0] y);
    bus.i_req_x[port*DW +: DW] = x;
    bus.i_req_y[port*DW +: DW] = y;
  endtask

  task automatic wait_gnt(output logic [N-1:0] g, output int t);
    g = '0;
    t = -1;
    for (int i = 0; i < 300; i++) begin
      @(negedge i_clk);
      if (bus.o_gnt != '0) begin
        g = bus.o_gnt;
        t = cyc;
        break;
      end
    end
  endtask

  task automatic wait_valid(output int t);
    t = -1;
    for (int i = 0; i < 300; i++) begin
      @(negedge i_clk);
      if (bus.o_rsp_valid != '0) begin
        t = cyc;
        break;
      end
    end
  endtask

  // Waits for the response, accepts it on the given port and returns the data.
  task automatic finish_txn(input int port, output logic [DW-1:0] d);
    int t;
    wait_valid(t);
    d = bus.o_rsp_data;
    bus.i_rsp_ready[port] = 1'b1;
    @(negedge i_clk);
    bus.i_rsp_ready = '0;
  endtask

  task automatic do_reset();
    i_rst = 1'b0;
    bus.i_req = '0;
    bus.i_rsp_ready = '0;
    hang = 1'b0;
    stray_done = 1'b0;
    repeat (3) @(negedge i_clk);
    i_rst = 1'b1;
    @(negedge i_clk);
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++;
    if (bus.o_gnt !== '0 || bus.o_rsp_valid !== '0 || bus.o_mul_start !== 1'b0) begin
      n_err++;
      $display("FAIL reset_handshake: gnt=%b valid=%b start=%b want all 0", bus.o_gnt, bus.o_rsp_valid, bus.o_mul_start);
    end
    n_cmp++;
    if (bus.o_rsp_data !== '0 || bus.o_mul_x !== '0 || bus.o_mul_y !== '0) begin
      n_err++;
      $display("FAIL reset_data: data=%0h x=%0h y=%0h want 0", bus.o_rsp_data, bus.o_mul_x, bus.o_mul_y);
    end
    n_cmp++;
    if (bus.o_busy !== 1'b0 || bus.o_timeout !== 1'b0) begin
      n_err++;
      $display("FAIL reset_flags: busy=%b timeout=%b want 0", bus.o_busy, bus.o_timeout);
    end
  endtask

  task automatic test_single();
    logic [N-1:0] g;
    int tg, tv;
    set_ops(0, 3, 5);
    bus.i_req = 4'b0001;
    wait_gnt(g, tg);
    bus.i_req = '0;
    n_cmp++;
    if (g !== 4'b0001) begin
      n_err++;
      $display("FAIL single_gnt: got %b want 0001", g);
    end
    @(negedge i_clk);
    n_cmp++;
    if (bus.o_gnt !== '0 || bus.o_mul_start !== 1'b1) begin
      n_err++;
      $display("FAIL single_start: gnt=%b start=%b want 0000/1", bus.o_gnt, bus.o_mul_start);
    end
    wait_valid(tv);
    n_cmp++;
    if (tv - tg !== 12) begin
      n_err++;
      $display("FAIL single_latency: got %0d want 12", tv - tg);
    end
    n_cmp++;
    if (bus.o_rsp_valid !== 4'b0001 || bus.o_rsp_data !== DW'(15)) begin
      n_err++;
      $display("FAIL single_rsp: valid=%b data=%0d want 0001/15", bus.o_rsp_valid, bus.o_rsp_data);
    end
    bus.i_rsp_ready = 4'b0001;
    @(negedge i_clk);
    bus.i_rsp_ready = '0;
    n_cmp++;
    if (bus.o_busy !== 1'b0 || bus.o_rsp_valid !== '0) begin
      n_err++;
      $display("FAIL single_idle: busy=%b valid=%b want 0/0000", bus.o_busy, bus.o_rsp_valid);
    end
  endtask

  task automatic test_round_robin();
    logic [N-1:0] exp_order [5];
    logic [N-1:0] g;
    int tg, tprev;
    exp_order = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    do_reset();
    for (int k = 0; k < N; k++) set_ops(k, DW'(k + 1), DW'(k + 2));
    bus.i_rsp_ready = 4'b1111;
    bus.i_req = 4'b1111;
    tprev = -1;
    for (int i = 0; i < 5; i++) begin
      wait_gnt(g, tg);
      if (i == 4) bus.i_req = '0;
      n_cmp++;
      if (g !== exp_order[i]) begin
        n_err++;
        $display("FAIL rr_order[%0d]: got %b want %b", i, g, exp_order[i]);
      end
      if (i > 0) begin
        n_cmp++;
        if (tg - tprev !== 14) begin
          n_err++;
          $display("FAIL rr_spacing[%0d]: got %0d want 14", i, tg - tprev);
        end
      end
      tprev = tg;
    end
    for (int i = 0; i < 300 && bus.o_busy; i++) @(negedge i_clk);
    bus.i_rsp_ready = '0;
  endtask

  task automatic test_wrap();
    logic [N-1:0] g;
    logic [DW-1:0] d;
    int tg;
    // Pointer is 0 here; granting port 1 moves it to 1.
    bus.i_req = 4'b0010;
    wait_gnt(g, tg);
    bus.i_req = '0;
    n_cmp++;
    if (g !== 4'b0010) begin
      n_err++;
      $display("FAIL wrap_setup: got %b want 0010", g);
    end
    finish_txn(1, d);
    set_ops(0, 2, 2);
    set_ops(3, 4, 4);
    bus.i_req = 4'b1001;
    wait_gnt(g, tg);
    bus.i_req = '0;
    n_cmp++;
    if (g !== 4'b1000) begin
      n_err++;
      $display("FAIL wrap_gnt: got %b want 1000", g);
    end
    finish_txn(3, d);
    n_cmp++;
    if (d !== DW'(16)) begin
      n_err++;
      $display("FAIL wrap_data: got %0d want 16", d);
    end
  endtask

  task automatic test_timeout();
    logic [N-1:0] g;
    logic [DW-1:0] d;
    int tg, tv;
    hang = 1'b1;
    set_ops(0, 9, 9);
    bus.i_req = 4'b0001;
    wait_gnt(g, tg);
    bus.i_req = '0;
    wait_valid(tv);
    n_cmp++;
    if (tv - tg !== 64) begin
      n_err++;
      $display("FAIL timeout_latency: got %0d want 64", tv - tg);
    end
    n_cmp++;
    if (bus.o_rsp_valid !== 4'b0001 || bus.o_rsp_data !== '0 || bus.o_timeout !== 1'b1) begin
      n_err++;
      $display("FAIL timeout_rsp: valid=%b data=%0h to=%b want 0001/0/1", bus.o_rsp_valid, bus.o_rsp_data, bus.o_timeout);
    end
    bus.i_rsp_ready = 4'b0001;
    @(negedge i_clk);
    bus.i_rsp_ready = '0;
    hang = 1'b0;
    set_ops(0, 7, 6);
    bus.i_req = 4'b0001;
    wait_gnt(g, tg);
    bus.i_req = '0;
    finish_txn(0, d);
    n_cmp++;
    if (d !== DW'(42) || bus.o_timeout !== 1'b1) begin
      n_err++;
      $display("FAIL timeout_sticky: data=%0d to=%b want 42/1", d, bus.o_timeout);
    end
  endtask

  task automatic test_stall();
    logic [N-1:0] g;
    int tg, tv;
    set_ops(2, 9, 11);
    bus.i_req = 4'b0100;
    wait_gnt(g, tg);
    bus.i_req = '0;
    wait_valid(tv);
    bus.i_rsp_ready = 4'b1011;
    for (int i = 0; i < 5; i++) begin
      stray_done = ~stray_done;
      @(negedge i_clk);
      n_cmp++;
      if (bus.o_rsp_valid !== 4'b0100 || bus.o_rsp_data !== DW'(99) || bus.o_mul_x !== DW'(9)) begin
        n_err++;
        $display("FAIL stall[%0d]: valid=%b data=%0d x=%0d want 0100/99/9", i, bus.o_rsp_valid, bus.o_rsp_data, bus.o_mul_x);
      end
    end
    stray_done = 1'b0;
    bus.i_rsp_ready = 4'b0100;
    @(negedge i_clk);
    bus.i_rsp_ready = '0;
    n_cmp++;
    if (bus.o_rsp_valid !== '0 || bus.o_busy !== 1'b0) begin
      n_err++;
      $display("FAIL stall_release: valid=%b busy=%b want 0000/0", bus.o_rsp_valid, bus.o_busy);
    end
  endtask

  task automatic test_reset_mid();
    logic [N-1:0] g;
    logic [DW-1:0] d;
    int tg, bad;
    set_ops(0, 100, 3);
    bus.i_req = 4'b0001;
    wait_gnt(g, tg);
    bus.i_req = '0;
    repeat (4) @(negedge i_clk);
    i_rst = 1'b0;
    #1;
    n_cmp++;
    if (bus.o_busy !== 1'b0 || bus.o_mul_x !== '0 || bus.o_mul_y !== '0 ||
        bus.o_timeout !== 1'b0 || bus.o_mul_start !== 1'b0 || bus.o_gnt !== '0) begin
      n_err++;
      $display("FAIL async_reset: busy=%b x=%0d y=%0d to=%b want all 0", bus.o_busy, bus.o_mul_x, bus.o_mul_y, bus.o_timeout);
    end
    @(negedge i_clk);
    i_rst = 1'b1;
    bad = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge i_clk);
      if (bus.o_rsp_valid !== '0 || bus.o_rsp_data !== '0) bad++;
    end
    n_cmp++;
    if (bad !== 0) begin
      n_err++;
      $display("FAIL reset_discard: %0d cycles with stale response, want 0", bad);
    end
    set_ops(2, 2, 4);
    bus.i_req = 4'b0100;
    wait_gnt(g, tg);
    bus.i_req = '0;
    n_cmp++;
    if (g !== 4'b0100) begin
      n_err++;
      $display("FAIL post_reset_gnt: got %b want 0100", g);
    end
    finish_txn(2, d);
    n_cmp++;
    if (d !== DW'(8)) begin
      n_err++;
      $display("FAIL post_reset_data: got %0d want 8", d);
    end
  endtask

  initial begin
    i_rst = 1'b0;
    hang = 1'b0;
    stray_done = 1'b0;
    bus.i_req = '0;
    bus.i_req_x = '0;
    bus.i_req_y = '0;
    bus.i_rsp_ready = '0;
    test_reset();
    test_single();
    test_round_robin();
    test_wrap();
    test_timeout();
    test_stall();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
